// File: rtl/seq_addsub.sv
// Digit-serial two's-complement adder/subtractor, DIGIT bits per clock, LSB slice first.
// Latency: out_valid rises N = WIDTH/DIGIT cycles after the accepting edge; one op in flight.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. Saturation: ADDSUB_SAT_EN.
module seq_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb, acc;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [DIGIT-1:0] sa, sb, dsum;
  logic             dcout, msb_cin, slice_ovf, last;
  logic [WIDTH-1:0] acc_nxt, fin_s;

  // One slice of the ripple: operands are shifted right each cycle so slice 0 is always the live one.
  always_comb begin
    sa        = opa[DIGIT-1:0];
    sb        = opb[DIGIT-1:0];
    {dcout, dsum} = {1'b0, sa} + {1'b0, sb} + {{DIGIT{1'b0}}, carry};
    // Carry into the slice MSB recovered from its sum bit, so DIGIT=1 needs no special case.
    msb_cin   = dsum[DIGIT-1] ^ sa[DIGIT-1] ^ sb[DIGIT-1];
    slice_ovf = msb_cin ^ dcout;
    last      = (idx == IW'(N - 1));
    // New digit enters at the top; after N shifts the accumulator holds the full sum.
    acc_nxt   = WIDTH'({dsum, acc} >> DIGIT);
    fin_s     = acc_nxt;
`ifdef ADDSUB_SAT_EN
    // On overflow the true result has the sign of A (B already conditioned); clamp toward it.
    if (slice_ovf) begin
      fin_s = sa[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: accept in IDLE, N slice cycles in RUN, hold in DONE until consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign s         = acc;

  // Datapath: capture operands on accept, then one slice per RUN cycle; flags written on the last slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub;
            idx   <= '0;
          end
        end
        RUN: begin
          opa   <= opa >> DIGIT;
          opb   <= opb >> DIGIT;
          carry <= dcout;
          idx   <= idx + 1'b1;
          if (last) begin
            acc  <= fin_s;
            cout <= dcout;
            ovf  <= slice_ovf;
            zero <= (fin_s == '0);
          end else begin
            acc  <= acc_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_addsub.sv
module tb_seq_addsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] s;
  logic        cout, ovf, zero;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    logic        z;
    int          acc;
  } exp_t;

  exp_t q[$];
  logic prev_ov = 1'b0;

  seq_addsub #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency on the first valid cycle, pop and compare on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov && q.size() > 0) check("latency", cyc - q[0].acc, 4);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = q.pop_front();
          check("s",    s,    e.s);
          check("cout", cout, e.c);
          check("ovf",  ovf,  e.o);
          check("zero", zero, e.z);
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic issue(input logic [15:0] ai, input logic [15:0] bi, input logic si,
                       input logic [15:0] es, input logic ec, input logic eo, input logic ez);
    int t = 0;
    exp_t e;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    a = ai; b = bi; sub = si; in_valid = 1'b1;
    @(posedge clk); #1;
    e.s = es; e.c = ec; e.o = eo; e.z = ez; e.acc = cyc;
    q.push_back(e);
    in_valid = 1'b0;
    // Scramble operands after capture; they must not influence the result.
    a = 16'($urandom); b = 16'($urandom); sub = ~si;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #12;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_s",         s,         0);
    check("rst_flags",     {cout, ovf, zero}, 0);
    @(negedge clk) rst_n = 1'b1;

    // Directed vectors, back to back.
    issue(16'h000D, 16'h0005, 1'b1, 16'h0008, 1'b1, 1'b0, 1'b0);
    issue(16'h000D, 16'h0005, 1'b0, 16'h0012, 1'b0, 1'b0, 1'b0);
    issue(16'h0005, 16'h000D, 1'b1, 16'hFFF8, 1'b0, 1'b0, 1'b0);
    issue(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    issue(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
`ifdef ADDSUB_SAT_EN
    issue(16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    issue(16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
    issue(16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
    issue(16'h7000, 16'h9000, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
`else
    issue(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    issue(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    issue(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    issue(16'h7000, 16'h9000, 1'b1, 16'hE000, 1'b0, 1'b1, 1'b0);
`endif
    drain();

    // Backpressure: hold DONE for 10 cycles with stray in_valid pulses.
    out_ready = 1'b0;
    issue(16'h0100, 16'h0023, 1'b0, 16'h0123, 1'b0, 1'b0, 1'b0);
    begin
      int t = 0;
      while (!out_valid && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      check("stall_reach_done", out_valid, 1);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = 16'hAAAA; b = 16'h5555; sub = 1'b1;
      @(posedge clk); #1;
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready",  in_ready,  0);
      check("stall_s",         s,         16'h0123);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready",  in_ready,  1);
    check("stall_popped",      q.size(),  0);

    // Reset during the second RUN cycle discards the operation.
    a = 16'h1234; b = 16'h4321; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready",  in_ready,  1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_s",         s,         0);
    check("midrst_flags",     {cout, ovf, zero}, 0);
    @(negedge clk) rst_n = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      check("midrst_no_result", seen, 0);
    end

    // Normal operation after reset.
    issue(16'h000D, 16'h0005, 1'b1, 16'h0008, 1'b1, 1'b0, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_addsub.md
SEQ_ADDSUB -- requirements
Module: seq_addsub

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a multiple of DIGIT.
REQ-002 Parameter DIGIT, default 4, bits processed per clock; N = WIDTH/DIGIT.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 a  input  WIDTH  operand A, two's complement.
REQ-008 b  input  WIDTH  operand B, two's complement.
REQ-009 sub  input  1  0 = A+B, 1 = A-B.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 s  output  WIDTH  result.
REQ-013 cout  output  1  carry out; for sub, 1 = no borrow (A >= B unsigned).
REQ-014 ovf  output  1  signed overflow of the unsaturated result.
REQ-015 zero  output  1  final s equals 0.

Function
REQ-016 FSM states IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 IDLE: in_valid=1 at an edge captures a, b, sub, sets carry = sub, digit index = 0, goes to RUN.
REQ-018 Subtraction SHALL be A + ~B + 1 (B inverted, carry-in 1); addition uses B, carry-in 0.
REQ-019 RUN: each cycle adds one DIGIT slice, LSB slice first, with the running carry; digit index increments.
REQ-020 RUN lasts exactly N cycles; out_valid rises N cycles after the accepting edge (N=1 when DIGIT=WIDTH).
REQ-021 ovf = carry into MSB XOR carry out of MSB, computed on the final slice.
REQ-022 DONE: s, cout, ovf, zero held stable while out_valid=1 and out_ready=0.
REQ-023 DONE with out_ready=1 at an edge returns to IDLE; out_valid drops next cycle; a new operation is accepted no earlier than the cycle after.
REQ-024 in_valid outside IDLE SHALL be ignored; a, b, sub changes after capture SHALL NOT affect the result.
REQ-025 Results wrap modulo 2^WIDTH when saturation is compiled out.

Reset
REQ-026 rst_n low asynchronously forces IDLE; in_ready=1, out_valid=0, s=0, cout=0, ovf=0, zero=0.
REQ-027 Reset during RUN or DONE discards the operation; no result is presented after release.
REQ-028 First accept possible on the first rising edge with rst_n high.

Configuration
REQ-029 Macro ADDSUB_SAT_EN defined: when ovf=1, s clamps to 2^(WIDTH-1)-1 if result sign should be positive, else -2^(WIDTH-1); ovf still reports 1; zero evaluated on clamped s.
REQ-030 ADDSUB_SAT_EN undefined: no clamp logic; s is the wrapped sum; all other behaviour identical.

Verification (WIDTH=16, DIGIT=4, N=4)
REQ-031 a=0x000D, b=0x0005, sub=1 -> s=0x0008, cout=1, ovf=0, zero=0; out_valid exactly 4 cycles after accept; a=0x000D, b=0x0005, sub=0 -> s=0x0012, cout=0.
REQ-032 a=0x0005, b=0x000D, sub=1 -> s=0xFFF8, cout=0, ovf=0; a=0x1234, b=0x1234, sub=1 -> s=0x0000, zero=1, cout=1.
REQ-033 a=0x7FFF, b=0x0001, sub=0 -> ovf=1; s=0x8000 without ADDSUB_SAT_EN, s=0x7FFF with it.
REQ-034 a=0x8000, b=0x0001, sub=1 -> ovf=1, cout=1; s=0x7FFF without ADDSUB_SAT_EN, s=0x8000 with it.
REQ-035 out_ready held 0 for 10 cycles in DONE -> out_valid=1, s unchanged, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-036 rst_n pulsed low during 2nd RUN cycle -> immediately in_ready=1, out_valid=0, s=0; no out_valid after release until a new accept.
